axi4_write_burst_master: RTL and testbench

Consumes the 512-bit write-data stream leaving the write FIFO and issues it to DRAM as AXI4 INCR write bursts at consecutive addresses. A transfer is started by a `start` pulse carrying a base address and a beat count. The block splits the transfer into bursts of at most `BURST_LEN` beats and never crosses a 4 KB boundary. It sits directly downstream of the write FIFO and upstream of the memory-side AXI4 interconnect.

---
 rtl/axi4_write_burst_master.sv | 167 ++++++++++++++++
 tb/tb_axi4_write_burst_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_burst_master.sv
// AXI4 INCR write-burst master: drains a 512-bit stream into DRAM as 4 KB-safe bursts.
// Optional BRESP error checking/abort is enabled by defining AXI4_WR_BRESP_CHECK_EN.
module axi4_write_burst_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [31:0]           cfg_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [511:0]          S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [511:0]          M_AXI_WDATA,
  output logic [63:0]           M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  localparam int unsigned LEN_W = 9;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                state;
  logic [31:0]           remaining;
  logic [7:0]            beat_cnt;
  logic [LEN_W-1:0]      cur_len;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           next_rem;
  logic [LEN_W-1:0]      start_len;
  logic [LEN_W-1:0]      next_len;
  logic                  bresp_abort;
  logic                  unused_bits;

  // Burst length limited by BURST_LEN, remaining beats and the distance to the next 4 KB page.
  function automatic logic [LEN_W-1:0] calc_len(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [31:0] rem);
    logic [LEN_W-1:0] room;
    logic [LEN_W-1:0] len;
    room = LEN_W'(64) - LEN_W'(a[11:6]);
    len  = LEN_W'(BURST_LEN);
    if (room < len) len = room;
    if (rem < 32'(len)) len = LEN_W'(rem);
    return len;
  endfunction

  assign cur_len    = LEN_W'(M_AXI_AWLEN) + LEN_W'(1);
  assign start_addr = {cfg_addr[ADDR_WIDTH-1:6], 6'd0};
  assign next_addr  = M_AXI_AWADDR + (ADDR_WIDTH'(cur_len) << 6);
  assign next_rem   = remaining - 32'(cur_len);
  assign start_len  = calc_len(start_addr, cfg_beats);
  assign next_len   = calc_len(next_addr, next_rem);

`ifdef AXI4_WR_BRESP_CHECK_EN
  assign bresp_abort = (M_AXI_BRESP != 2'b00);
  assign unused_bits = ^cfg_addr[5:0];

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == S_B && M_AXI_BVALID && bresp_abort) begin
      err <= 1'b1;
    end
  end
`else
  assign bresp_abort = 1'b0;
  assign err         = 1'b0;
  assign unused_bits = ^{cfg_addr[5:0], M_AXI_BRESP};
`endif

  // Write-data channel is a straight pass-through of the stream while in W.
  assign M_AXI_WVALID  = (state == S_W) && S_AXIS_TVALID;
  assign S_AXIS_TREADY = (state == S_W) && M_AXI_WREADY;
  assign M_AXI_WDATA   = S_AXIS_TDATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWSIZE  = 3'b110;
  assign M_AXI_AWBURST = 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      remaining     <= '0;
      beat_cnt      <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWLEN   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WLAST   <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy still high here means this is the done cycle; start is ignored
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy <= 1'b1;
            if (cfg_beats == 32'd0) begin
              done <= 1'b1;
            end else begin
              M_AXI_AWADDR  <= start_addr;
              remaining     <= cfg_beats;
              M_AXI_AWLEN   <= 8'(start_len - LEN_W'(1));
              M_AXI_AWVALID <= 1'b1;
              state         <= S_AW;
            end
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            beat_cnt      <= '0;
            M_AXI_WLAST   <= (M_AXI_AWLEN == 8'd0);
            state         <= S_W;
          end
        end
        S_W: begin
          if (S_AXIS_TVALID && M_AXI_WREADY) begin
            if (M_AXI_WLAST) begin
              M_AXI_WLAST  <= 1'b0;
              M_AXI_BREADY <= 1'b1;
              state        <= S_B;
            end else begin
              beat_cnt    <= beat_cnt + 8'd1;
              M_AXI_WLAST <= ((beat_cnt + 8'd1) == M_AXI_AWLEN);
            end
          end
        end
        S_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (bresp_abort || next_rem == 32'd0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              M_AXI_AWADDR  <= next_addr;
              remaining     <= next_rem;
              M_AXI_AWLEN   <= 8'(next_len - LEN_W'(1));
              M_AXI_AWVALID <= 1'b1;
              state         <= S_AW;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_write_burst_master.sv
// Directed bench for axi4_write_burst_master with a cycle-driven AXI slave and stream source.
module tb_axi4_write_burst_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  cfg_addr;
  logic [31:0]  cfg_beats;
  logic         busy, done, err;
  logic [511:0] tdata;
  logic         tvalid, tready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];

  axi4_write_burst_master #(.ADDR_WIDTH(32), .BURST_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_beats(cfg_beats),
    .busy(busy), .done(done), .err(err),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int k);
    logic [31:0] w;
    w = 32'(k) ^ 32'h5A5A_0000;
    return {16{w}};
  endfunction

  task automatic idle_inputs();
    start = 1'b0; cfg_addr = '0; cfg_beats = '0;
    tdata = '0; tvalid = 1'b0; wready = 1'b0; awready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  // Runs one transfer against the expected AW list; called at a negedge.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] beats, input bit stall,
                          input logic [1:0] bresp0, input int exp_beats, input int exp_done_n);
    int n = 1;
    int beat = 0;
    int aw_i = 0;
    int wb = 0;
    int cur_len = 0;
    int b_i = 0;
    bit pend_b = 0;
    bit fin = 0;
    start = 1'b1; cfg_addr = addr; cfg_beats = beats;
    @(negedge clk);
    while (!fin && n < 3000) begin
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tvalid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = pend_b && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      bresp   = (b_i == 0) ? bresp0 : 2'b00;
      tdata   = pat(beat);
      start   = stall && busy && ($urandom_range(0, 3) == 0);
      cfg_addr = 32'hDEAD_0040; cfg_beats = 32'd5;
      #1;
      if (n == 1) begin
        chk("awvalid_after_start", awvalid, 1'b1);
        chk("busy_after_start", busy, 1'b1);
      end
      if (awvalid && awready) begin
        if (aw_i < exp_aw_addr.size()) begin
          chk("aw_addr", awaddr, exp_aw_addr[aw_i]);
          chk("aw_len", awlen, exp_aw_len[aw_i]);
          cur_len = int'(exp_aw_len[aw_i]) + 1;
        end else begin
          chk("aw_extra", aw_i, exp_aw_addr.size());
        end
        chk("aw_size_burst", {awsize, awburst}, 5'b110_01);
        chk("tready_in_aw", tready, 1'b0);
        aw_i++;
        wb = 0;
      end
      if (wvalid && wready) begin
        chk("wdata", wdata, pat(beat));
        chk("wlast", wlast, (wb == cur_len - 1));
        chk("wstrb", wstrb, {64{1'b1}});
        chk("tready_in_w", tready, 1'b1);
        beat++;
        wb++;
        if (wb == cur_len) pend_b = 1;
      end
      if (bready && bvalid) begin
        chk("tready_in_b", tready, 1'b0);
        pend_b = 0;
        b_i++;
      end
      if (done) begin
        fin = 1;
        chk("busy_on_done", busy, 1'b1);
        if (exp_done_n >= 0) chk("done_cycle", n, exp_done_n);
      end
      @(negedge clk);
      n++;
    end
    idle_inputs();
    chk("timeout", fin, 1'b1);
    chk("beat_count", beat, exp_beats);
    chk("aw_count", aw_i, exp_aw_addr.size());
    chk("done_single_pulse", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_busy_done_err", {busy, done, err}, 3'b000);
    chk("rst_valids", {awvalid, wvalid, wlast, bready, tready}, 5'b00000);
    chk("rst_awaddr_awlen", {awaddr, awlen}, 40'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single full burst
    exp_aw_addr = '{32'h0000_0000};
    exp_aw_len  = '{8'd15};
    run_xfer(32'h0, 32'd16, 1'b0, 2'b00, 16, 19);

    // Three bursts, last one short
    exp_aw_addr = '{32'h0000_0000, 32'h0000_0400, 32'h0000_0800};
    exp_aw_len  = '{8'd15, 8'd15, 8'd7};
    run_xfer(32'h0, 32'd40, 1'b0, 2'b00, 40, 47);

    // 4 KB boundary split; low address bits are ignored
    exp_aw_addr = '{32'h0000_0F80, 32'h0000_1000};
    exp_aw_len  = '{8'd1, 8'd7};
    run_xfer(32'h0000_0F95, 32'd10, 1'b0, 2'b00, 10, 15);

    // Zero-beat transfer
    start = 1'b1; cfg_addr = 32'h100; cfg_beats = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_awvalid", awvalid, 1'b0);
    @(negedge clk);
    chk("zero_done_clear", done, 1'b0);
    chk("zero_awvalid_after", awvalid, 1'b0);

    // Random stalls over 100 beats, with start pulses while busy
    exp_aw_addr = '{32'h3E40, 32'h4000, 32'h4400, 32'h4800, 32'h4C00, 32'h5000, 32'h5400};
    exp_aw_len  = '{8'd6, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'd12};
    run_xfer(32'h3E40, 32'd100, 1'b1, 2'b00, 100, -1);

    // Reset in the middle of a transfer
    start = 1'b1; cfg_addr = 32'h0; cfg_beats = 32'd40;
    awready = 1'b1; tvalid = 1'b1; wready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_in_w", tready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_done", {busy, done, err}, 3'b000);
    chk("midrst_valids", {awvalid, wvalid, wlast, bready, tready}, 5'b00000);
    chk("midrst_awaddr_awlen", {awaddr, awlen}, 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Fresh transfer after reset starts from its own base
    exp_aw_addr = '{32'h0000_0F80, 32'h0000_1000};
    exp_aw_len  = '{8'd1, 8'd7};
    run_xfer(32'h0000_0F80, 32'd10, 1'b0, 2'b00, 10, 15);

`ifdef AXI4_WR_BRESP_CHECK_EN
    // Error response aborts after the first burst
    exp_aw_addr = '{32'h0};
    exp_aw_len  = '{8'd15};
    run_xfer(32'h0, 32'd48, 1'b0, 2'b10, 16, 19);
    chk("err_set", err, 1'b1);
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1'b1);
    chk("no_more_aw", awvalid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("err_cleared_by_reset", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`else
    // Error response is ignored and the transfer completes
    exp_aw_addr = '{32'h0, 32'h400, 32'h800};
    exp_aw_len  = '{8'd15, 8'd15, 8'd15};
    run_xfer(32'h0, 32'd48, 1'b0, 2'b10, 48, 55);
    chk("err_tied_low", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
